nrisc_decode_regfile: RTL and testbench
=======================================

// Module: nrisc_decode_regfile
// PURPOSE
// - Decode/register stage of the 8-bit nRisc single-cycle core. Combines three parts:
//   - the opcode control unit;
//   - the 2-to-3-bit register-field widener;
//   - the 8x8-bit register file.
// - Takes the fetched 8-bit instruction, the chosen write index and the write data.
// - Produces all datapath control strobes and the register read operands for the ALU, PC mux and memory.
// PARAMETERS
// - none (8-bit data, 8 registers, 3-bit opcode are fixed)
// PORTS
// - Clock           in   1  single clock, rising edge
// - Reset           in   1  synchronous, active-high
// - Instrucao       in   8  [7:5] opcode, [4:3] rs field, [2:0] rt / immediate
// - RegEscrito      in   3  write index (external RegDest mux: {0,rs} or 3'b001)
// - DadoEscritoReg  in   8  write data (external MemToReg/MoveReg muxes)
// - RegLido1        out  3  widened rs index = {1'b0, Instrucao[4:3]}
// - DadoLido1       out  8  R[RegLido1]
// - DadoLido2       out  8  R[Instrucao[2:0]]
// - Dadoa0          out  8  R[0] (a0), always visible
// - MemToReg, EscMem, LerMem, Branch, ULAFonte, EscReg, Jump, EscPc, MoveReg, RegDest  out  1 each
// - ULAOp           out  2  00 add, 01 sub, 10 pass operand2, 11 set-less-than
// BEHAVIOUR
// Widener
// - RegLido1 = {1'b0, Instrucao[4:3]}.
// - Combinational, so the rs field only reaches R0..R3.
// Control unit
// - Combinational on Instrucao[7:5].
// - Every strobe not listed for an opcode is 0.
//   - 000 ADD: EscReg=1, ULAOp=00, EscPc=1
//   - 001 SUB: EscReg=1, ULAOp=01, EscPc=1
//   - 010 SLT: EscReg=1, RegDest=1 (result to R1), ULAOp=11, EscPc=1
//   - 011 LD:  LerMem=1, MemToReg=1, ULAFonte=1, ULAOp=10, EscReg=1, EscPc=1
//   - 100 ST:  EscMem=1, ULAFonte=1, ULAOp=10, EscPc=1
//   - 101 BEQ: Branch=1, ULAOp=01, EscPc=1
//   - 110 JR:  Jump=1, EscPc=1
//   - 111 MOV: MoveReg=1, EscReg=1, EscPc=1
// - While Reset=1, all control outputs are forced to 0, including EscPc, EscReg and EscMem.
//   No state update is requested during reset.
// Register file
// - 8 registers x 8 bits; all 8 are writable, including R0 and R1.
// - Reads are asynchronous: DadoLido1, DadoLido2 and Dadoa0 follow the index and the register contents combinationally.
// - Write: on rising Clock with EscReg=1 and Reset=0, R[RegEscrito] <= DadoEscritoReg.
// - Reset: on rising Clock with Reset=1, all registers <= 8'h00. Reset wins over a simultaneous write.
// - Read during write, same index: the read returns the old value until the edge, and the new value after the edge (no bypass).
// - Only one write port, so at most one write per cycle.
// - Reset mid-program: the next edge clears every register; the outputs read 0 from then on.
// - No X propagation: all storage is defined after the first reset edge.
// TESTING
// - Reset=1 for one edge -> all registers read 8'h00; every control output = 0.
// - Reset=0, Instrucao=8'b000_01_010 (ADD) -> EscReg=1, ULAOp=00, EscPc=1, RegDest=0; RegLido1=3'b001.
// - RegEscrito=3, DadoEscritoReg=8'hA5, ADD opcode, one edge -> Instrucao[2:0]=3 gives DadoLido2=8'hA5.
//   Before that edge DadoLido2 still shows the old value.
// - Opcode 011 (LD) -> LerMem=MemToReg=ULAFonte=EscReg=1, ULAOp=10.
//   Opcode 100 (ST) -> EscMem=1, EscReg=0; no register changes across the edge.
// - Write R0=8'h3C via MOV (opcode 111) -> Dadoa0=8'h3C. Opcode 110 -> Jump=1, EscReg=0.
//   Opcode 101 -> Branch=1, ULAOp=01.
// - EscReg asserted together with Reset=1 on one edge -> target register reads 8'h00 (reset wins).

Source files
------------

// File: rtl/nrisc_decode_regfile.sv
// -----------------------------------------------------------------------------
// nrisc_decode_regfile
// Decode/register stage of the 8-bit nRisc single-cycle core. It holds the
// opcode control unit, the 2-to-3-bit rs-field widener and the 8x8 register
// file.
//
// Ports
//   i_clk              rising-edge clock
//   i_rst              synchronous active-high reset
//   i_instrucao[7:0]   [7:5] opcode, [4:3] rs field, [2:0] rt / immediate
//   i_reg_escrito[2:0] write index (from the external RegDest mux)
//   i_dado_escrito_reg write data (from the external MemToReg/MoveReg muxes)
//   o_reg_lido1[2:0]   widened rs index {1'b0, rs}
//   o_dado_lido1       R[o_reg_lido1]
//   o_dado_lido2       R[i_instrucao[2:0]]
//   o_dado_a0          R[0], always visible
//   o_mem_to_reg .. o_reg_dest  single-bit datapath strobes
//   o_ula_op[1:0]      00 add, 01 sub, 10 pass operand2, 11 set-less-than
// -----------------------------------------------------------------------------
module nrisc_decode_regfile (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_instrucao,
    input  logic [2:0] i_reg_escrito,
    input  logic [7:0] i_dado_escrito_reg,
    output logic [2:0] o_reg_lido1,
    output logic [7:0] o_dado_lido1,
    output logic [7:0] o_dado_lido2,
    output logic [7:0] o_dado_a0,
    output logic       o_mem_to_reg,
    output logic       o_esc_mem,
    output logic       o_ler_mem,
    output logic       o_branch,
    output logic       o_ula_fonte,
    output logic       o_esc_reg,
    output logic       o_jump,
    output logic       o_esc_pc,
    output logic       o_move_reg,
    output logic       o_reg_dest,
    output logic [1:0] o_ula_op
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SLT = 3'b010,
        OP_LD  = 3'b011,
        OP_ST  = 3'b100,
        OP_BEQ = 3'b101,
        OP_JR  = 3'b110,
        OP_MOV = 3'b111
    } opcode_t;

    localparam logic [1:0] ULA_ADD  = 2'b00;
    localparam logic [1:0] ULA_SUB  = 2'b01;
    localparam logic [1:0] ULA_PASS = 2'b10;
    localparam logic [1:0] ULA_SLT  = 2'b11;

    opcode_t    w_opcode;
    logic [2:0] w_rs_idx;
    logic [2:0] w_rt_idx;

    // Raw decode before reset gating
    logic       w_mem_to_reg;
    logic       w_esc_mem;
    logic       w_ler_mem;
    logic       w_branch;
    logic       w_ula_fonte;
    logic       w_esc_reg;
    logic       w_jump;
    logic       w_esc_pc;
    logic       w_move_reg;
    logic       w_reg_dest;
    logic [1:0] w_ula_op;

    logic [7:0] r_regs [8];

    assign w_opcode = opcode_t'(i_instrucao[7:5]);

    // The rs field is only two bits wide, so rs can only name R0..R3.
    assign w_rs_idx = {1'b0, i_instrucao[4:3]};
    assign w_rt_idx = i_instrucao[2:0];

    // ------------------------------------------------------------------
    // Control unit
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_to_reg = 1'b0;
        w_esc_mem    = 1'b0;
        w_ler_mem    = 1'b0;
        w_branch     = 1'b0;
        w_ula_fonte  = 1'b0;
        w_esc_reg    = 1'b0;
        w_jump       = 1'b0;
        w_esc_pc     = 1'b1;
        w_move_reg   = 1'b0;
        w_reg_dest   = 1'b0;
        w_ula_op     = ULA_ADD;
        case (w_opcode)
            OP_ADD: begin
                w_esc_reg = 1'b1;
                w_ula_op  = ULA_ADD;
            end
            OP_SUB: begin
                w_esc_reg = 1'b1;
                w_ula_op  = ULA_SUB;
            end
            OP_SLT: begin
                // SLT always writes its flag to R1
                w_esc_reg  = 1'b1;
                w_reg_dest = 1'b1;
                w_ula_op   = ULA_SLT;
            end
            OP_LD: begin
                w_ler_mem    = 1'b1;
                w_mem_to_reg = 1'b1;
                w_ula_fonte  = 1'b1;
                w_esc_reg    = 1'b1;
                w_ula_op     = ULA_PASS;
            end
            OP_ST: begin
                w_esc_mem   = 1'b1;
                w_ula_fonte = 1'b1;
                w_ula_op    = ULA_PASS;
            end
            OP_BEQ: begin
                w_branch = 1'b1;
                w_ula_op = ULA_SUB;
            end
            OP_JR: begin
                w_jump = 1'b1;
            end
            OP_MOV: begin
                w_move_reg = 1'b1;
                w_esc_reg  = 1'b1;
            end
            default: begin
                w_esc_pc = 1'b1;
            end
        endcase
    end

    // While reset is held no strobe may request a state update anywhere
    // in the core, so every control output is squashed here.
    always_comb begin
        o_mem_to_reg = w_mem_to_reg & ~i_rst;
        o_esc_mem    = w_esc_mem    & ~i_rst;
        o_ler_mem    = w_ler_mem    & ~i_rst;
        o_branch     = w_branch     & ~i_rst;
        o_ula_fonte  = w_ula_fonte  & ~i_rst;
        o_esc_reg    = w_esc_reg    & ~i_rst;
        o_jump       = w_jump       & ~i_rst;
        o_esc_pc     = w_esc_pc     & ~i_rst;
        o_move_reg   = w_move_reg   & ~i_rst;
        o_reg_dest   = w_reg_dest   & ~i_rst;
        o_ula_op     = i_rst ? 2'b00 : w_ula_op;
    end

    // ------------------------------------------------------------------
    // Register file: single write port, asynchronous reads, no bypass
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (w_esc_reg) begin
            r_regs[i_reg_escrito] <= i_dado_escrito_reg;
        end
    end

    assign o_reg_lido1  = w_rs_idx;
    assign o_dado_lido1 = r_regs[w_rs_idx];
    assign o_dado_lido2 = r_regs[w_rt_idx];
    assign o_dado_a0    = r_regs[0];

endmodule

// File: tb/tb_nrisc_decode_regfile.sv
// -----------------------------------------------------------------------------
// tb_nrisc_decode_regfile
// Drives one instruction per cycle, pushes the expected decode/read values
// into a scoreboard queue, and pops/compares them half a cycle later. A small
// register model tracks writes and resets across clock edges.
// -----------------------------------------------------------------------------
module tb_nrisc_decode_regfile;

    logic       clk;
    logic       rst;
    logic [7:0] instrucao;
    logic [2:0] reg_escrito;
    logic [7:0] dado_escrito;
    logic [2:0] reg_lido1;
    logic [7:0] dado_lido1;
    logic [7:0] dado_lido2;
    logic [7:0] dado_a0;
    logic       mem_to_reg, esc_mem, ler_mem, branch, ula_fonte;
    logic       esc_reg, jump, esc_pc, move_reg, reg_dest;
    logic [1:0] ula_op;

    nrisc_decode_regfile dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_instrucao        (instrucao),
        .i_reg_escrito      (reg_escrito),
        .i_dado_escrito_reg (dado_escrito),
        .o_reg_lido1        (reg_lido1),
        .o_dado_lido1       (dado_lido1),
        .o_dado_lido2       (dado_lido2),
        .o_dado_a0          (dado_a0),
        .o_mem_to_reg       (mem_to_reg),
        .o_esc_mem          (esc_mem),
        .o_ler_mem          (ler_mem),
        .o_branch           (branch),
        .o_ula_fonte        (ula_fonte),
        .o_esc_reg          (esc_reg),
        .o_jump             (jump),
        .o_esc_pc           (esc_pc),
        .o_move_reg         (move_reg),
        .o_reg_dest         (reg_dest),
        .o_ula_op           (ula_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] ctrl;
        logic [2:0]  rl1;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  a0;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] m_regs [8];
    int         n_checks = 0;
    int         n_pass   = 0;

    // {mem_to_reg, esc_mem, ler_mem, branch, ula_fonte, esc_reg,
    //  jump, esc_pc, move_reg, reg_dest, ula_op[1:0]}
    function automatic logic [11:0] ctrl_model(input logic [2:0] op);
        case (op)
            3'b000:  return 12'b0000_0101_0000;
            3'b001:  return 12'b0000_0101_0001;
            3'b010:  return 12'b0000_0101_0111;
            3'b011:  return 12'b1010_1101_0010;
            3'b100:  return 12'b0100_1001_0010;
            3'b101:  return 12'b0001_0001_0001;
            3'b110:  return 12'b0000_0011_0000;
            default: return 12'b0000_0101_1000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, queue expected values (pre-edge contents),
    // compare at the falling edge, then advance the model at the rising edge.
    task automatic apply(input logic r, input logic [7:0] ins,
                         input logic [2:0] widx, input logic [7:0] wdat);
        exp_t       e;
        exp_t       got;
        logic [11:0] c;
        logic [2:0]  rs;
        rst          = r;
        instrucao    = ins;
        reg_escrito  = widx;
        dado_escrito = wdat;
        c    = r ? 12'h000 : ctrl_model(ins[7:5]);
        rs   = {1'b0, ins[4:3]};
        e.ctrl = c;
        e.rl1  = rs;
        e.d1   = m_regs[rs];
        e.d2   = m_regs[ins[2:0]];
        e.a0   = m_regs[0];
        sb_q.push_back(e);

        @(negedge clk);
        got.ctrl = {mem_to_reg, esc_mem, ler_mem, branch, ula_fonte, esc_reg,
                    jump, esc_pc, move_reg, reg_dest, ula_op};
        got.rl1  = reg_lido1;
        got.d1   = dado_lido1;
        got.d2   = dado_lido2;
        got.a0   = dado_a0;
        e = sb_q.pop_front();
        check("ctrl",      {4'h0, got.ctrl}, {4'h0, e.ctrl});
        check("reg_lido1", {13'h0, got.rl1}, {13'h0, e.rl1});
        check("dado_lido1", {8'h0, got.d1},  {8'h0, e.d1});
        check("dado_lido2", {8'h0, got.d2},  {8'h0, e.d2});
        check("dado_a0",    {8'h0, got.a0},  {8'h0, e.a0});

        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        end else if (c[6]) begin
            m_regs[widx] = wdat;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        rst          = 1'b1;
        instrucao    = 8'h00;
        reg_escrito  = 3'd0;
        dado_escrito = 8'h00;
        @(posedge clk);
        #1;

        // Reset held: all controls 0, all registers 0
        apply(1'b1, 8'b000_01_010, 3'd2, 8'h11);
        // ADD decode, rs=1 -> reg_lido1=001
        apply(1'b0, 8'b000_01_010, 3'd3, 8'hA5);
        // R3 was just written; reading it now shows A5 (pre-edge of this cycle)
        apply(1'b0, 8'b011_00_011, 3'd4, 8'h5A);
        // ST: no register write even though index/data are presented
        apply(1'b0, 8'b100_00_011, 3'd3, 8'hFF);
        apply(1'b0, 8'b001_00_011, 3'd6, 8'h66);
        // MOV into R0
        apply(1'b0, 8'b111_00_000, 3'd0, 8'h3C);
        apply(1'b0, 8'b110_00_000, 3'd0, 8'hEE);
        apply(1'b0, 8'b101_11_100, 3'd1, 8'hDD);
        // SLT writes R1
        apply(1'b0, 8'b010_01_001, 3'd1, 8'h01);
        // Reset wins over a simultaneous write
        apply(1'b0, 8'b000_00_101, 3'd5, 8'h77);
        apply(1'b1, 8'b000_00_101, 3'd5, 8'h99);
        apply(1'b0, 8'b001_00_101, 3'd7, 8'h42);

        for (int k = 0; k < 80; k++) begin
            logic [7:0] ins;
            logic [2:0] widx;
            logic [7:0] wdat;
            logic       r;
            ins  = 8'($urandom);
            widx = 3'($urandom);
            wdat = 8'($urandom);
            r    = ($urandom_range(0, 19) == 0);
            apply(r, ins, widx, wdat);
        end

        if (sb_q.size() != 0) begin
            check("sb_empty", 16'(sb_q.size()), 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
